// File: rtl/mgmt_sram_arbiter.sv
// Arbiter sharing one single-port DFFRAM-style SRAM between the CPU and NRO
// read-only client channels, with CPU priority, round-robin and starvation override.
module mgmt_sram_arbiter #(
   parameter int AW         = 8,
   parameter int DW         = 32,
   parameter int NRO        = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic              core_clk,
   input  logic              core_rst,
   input  logic              cpu_en,
   input  logic [DW/8-1:0]   cpu_we,
   input  logic [AW-1:0]     cpu_a,
   input  logic [DW-1:0]     cpu_di,
   output logic [DW-1:0]     cpu_do,
   output logic              cpu_stall,
   input  logic [NRO-1:0]    ro_req,
   input  logic [NRO*AW-1:0] ro_addr,
   output logic [NRO-1:0]    ro_ack,
   output logic [NRO*DW-1:0] ro_data,
   output logic              ram_en,
   output logic [DW/8-1:0]   ram_we,
   output logic [AW-1:0]     ram_a,
   output logic [DW-1:0]     ram_di,
   input  logic [DW-1:0]     ram_do
);

   // state  | meaning
   // S_IDLE | no request in progress; pending when ro_req high and re-armed
   // S_WAIT | request pending, not yet granted; wait counter running
   // S_RD1  | granted last cycle; ram_do valid now, captured at end of cycle
   // S_RD2  | holding register updated, ro_ack high for this cycle
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RD1, S_RD2} ch_state_t;

   localparam int WB = DW / 8;
   localparam int PW = (NRO > 1) ? $clog2(NRO) : 1;
   localparam int CW = $clog2(STARVE_LIM + 1);

   ch_state_t       state_q [NRO];
   logic [CW-1:0]   wait_q  [NRO];
   logic [DW-1:0]   hold_q  [NRO];
   logic [NRO-1:0]  armed_q;
   logic [NRO-1:0]  ack_q;
   logic [PW-1:0]   rr_q;
   logic            cpu_rd_q;
   logic [DW-1:0]   cpu_do_q;

   logic [NRO-1:0]  pending;
   logic [NRO-1:0]  starved;
   logic [NRO-1:0]  ro_gnt;
   logic            ro_gnt_any;
   logic [PW-1:0]   ro_gnt_idx;
   logic            cpu_gnt;

   function automatic logic [PW-1:0] first_from(input logic [NRO-1:0] vec,
                                                input logic [PW-1:0]  ptr);
      logic [PW-1:0] sel;
      logic          found;
      int            idx;
      sel   = ptr;
      found = 1'b0;
      for (int k = 0; k < NRO; k++) begin
         idx = (int'(ptr) + k) % NRO;
         if (!found && vec[idx]) begin
            found = 1'b1;
            sel   = PW'(idx);
         end
      end
      return sel;
   endfunction

   always_comb begin
      pending = '0;
      starved = '0;
      for (int i = 0; i < NRO; i++) begin
         pending[i] = ro_req[i] &&
                      ((state_q[i] == S_IDLE && armed_q[i]) || state_q[i] == S_WAIT);
         starved[i] = pending[i] && (wait_q[i] == CW'(STARVE_LIM));
      end
   end

   // Slot decision; reset forces the SRAM idle regardless of requests.
   always_comb begin
      ro_gnt_any = 1'b0;
      ro_gnt_idx = '0;
      cpu_gnt    = 1'b0;
      cpu_stall  = 1'b0;
      if (!core_rst) begin
         if (|starved) begin
            ro_gnt_any = 1'b1;
            ro_gnt_idx = first_from(starved, rr_q);
            cpu_stall  = cpu_en;
         end else if (cpu_en) begin
            cpu_gnt = 1'b1;
         end else if (|pending) begin
            ro_gnt_any = 1'b1;
            ro_gnt_idx = first_from(pending, rr_q);
         end
      end
   end

   always_comb begin
      ro_gnt = '0;
      for (int i = 0; i < NRO; i++)
         ro_gnt[i] = ro_gnt_any && (ro_gnt_idx == PW'(i));
   end

   always_comb begin
      ram_en = cpu_gnt | ro_gnt_any;
      ram_we = '0;
      ram_a  = '0;
      ram_di = '0;
      if (cpu_gnt) begin
         ram_we = cpu_we;
         ram_a  = cpu_a;
         ram_di = cpu_di;
      end else if (ro_gnt_any) begin
         ram_a  = ro_addr[ro_gnt_idx*AW +: AW];
      end
   end

   always_ff @(posedge core_clk or posedge core_rst) begin
      if (core_rst) begin
         for (int i = 0; i < NRO; i++) begin
            state_q[i] <= S_IDLE;
            wait_q[i]  <= '0;
            hold_q[i]  <= '0;
         end
         armed_q  <= '1;
         ack_q    <= '0;
         rr_q     <= '0;
         cpu_rd_q <= 1'b0;
         cpu_do_q <= '0;
      end else begin
         for (int i = 0; i < NRO; i++) begin
            ack_q[i] <= 1'b0;
            case (state_q[i])
               S_IDLE: begin
                  if (!ro_req[i])
                     armed_q[i] <= 1'b1;
                  if (pending[i]) begin
                     if (ro_gnt[i]) begin
                        state_q[i] <= S_RD1;
                        wait_q[i]  <= '0;
                     end else begin
                        state_q[i] <= S_WAIT;
                        if (wait_q[i] != CW'(STARVE_LIM))
                           wait_q[i] <= wait_q[i] + 1'b1;
                     end
                  end
               end
               S_WAIT: begin
                  if (!ro_req[i]) begin
                     state_q[i] <= S_IDLE;
                     wait_q[i]  <= '0;
                  end else if (ro_gnt[i]) begin
                     state_q[i] <= S_RD1;
                     wait_q[i]  <= '0;
                  end else if (wait_q[i] != CW'(STARVE_LIM)) begin
                     wait_q[i] <= wait_q[i] + 1'b1;
                  end
               end
               S_RD1: begin
                  hold_q[i]  <= ram_do;
                  ack_q[i]   <= 1'b1;
                  state_q[i] <= S_RD2;
               end
               default: begin
                  // A request still high across the ack must drop before it counts again.
                  armed_q[i] <= ~ro_req[i];
                  state_q[i] <= S_IDLE;
               end
            endcase
         end

         if (ro_gnt_any) begin
            if (ro_gnt_idx == PW'(NRO - 1))
               rr_q <= '0;
            else
               rr_q <= ro_gnt_idx + 1'b1;
         end

         cpu_rd_q <= cpu_gnt && (cpu_we == '0);
         if (cpu_rd_q)
            cpu_do_q <= ram_do;
      end
   end

   // Read data is passed straight through in the return cycle, then held.
   assign cpu_do = cpu_rd_q ? ram_do : cpu_do_q;
   assign ro_ack = ack_q;

   for (genvar g = 0; g < NRO; g++) begin : g_ro_data
      assign ro_data[g*DW +: DW] = hold_q[g];
   end

endmodule

// File: tb/tb_mgmt_sram_arbiter.sv
// Directed bench for mgmt_sram_arbiter with an SRAM stand-in and a
// cycle-level behavioural model of the arbitration rules.
module tb_mgmt_sram_arbiter;

   localparam int AW  = 8;
   localparam int DW  = 32;
   localparam int NRO = 2;
   localparam int LIM = 4;
   localparam int WB  = DW / 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              cpu_en;
   logic [WB-1:0]     cpu_we;
   logic [AW-1:0]     cpu_a;
   logic [DW-1:0]     cpu_di;
   logic [DW-1:0]     cpu_do;
   logic              cpu_stall;
   logic [NRO-1:0]    ro_req;
   logic [NRO*AW-1:0] ro_addr;
   logic [NRO-1:0]    ro_ack;
   logic [NRO*DW-1:0] ro_data;
   logic              ram_en;
   logic [WB-1:0]     ram_we;
   logic [AW-1:0]     ram_a;
   logic [DW-1:0]     ram_di;
   logic [DW-1:0]     ram_do;

   int nvec  = 0;
   int nfail = 0;

   mgmt_sram_arbiter #(.AW(AW), .DW(DW), .NRO(NRO), .STARVE_LIM(LIM)) dut (
      .core_clk(clk), .core_rst(rst),
      .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_a(cpu_a), .cpu_di(cpu_di),
      .cpu_do(cpu_do), .cpu_stall(cpu_stall),
      .ro_req(ro_req), .ro_addr(ro_addr), .ro_ack(ro_ack), .ro_data(ro_data),
      .ram_en(ram_en), .ram_we(ram_we), .ram_a(ram_a), .ram_di(ram_di),
      .ram_do(ram_do)
   );

   always #5 clk = ~clk;

   // SRAM stand-in: byte-write, registered read output.
   logic [DW-1:0] sram [256];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we != '0) begin
            for (int b = 0; b < WB; b++)
               if (ram_we[b]) sram[ram_a][8*b +: 8] <= ram_di[8*b +: 8];
         end else begin
            ram_do <= sram[ram_a];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Model: age 0 = no read in flight, 1 = data returning, 2 = ack cycle.
   int            m_age     [NRO];
   int            m_wait    [NRO];
   bit            m_waiting [NRO];
   bit            m_armed   [NRO];
   logic [DW-1:0] m_rdval   [NRO];
   logic [DW-1:0] m_hold    [NRO];
   logic [DW-1:0] m_mem     [256];
   logic [DW-1:0] m_cpu_do;
   int            m_rr;

   initial begin
      for (int a = 0; a < 256; a++) begin
         sram[a]  = '0;
         m_mem[a] = '0;
      end
      ram_do = '0;
   end

   always @(negedge clk) begin
      bit            elig [NRO];
      int            g;
      int            idx;
      bit            cpu_g;
      bit            exp_stall;
      logic [AW-1:0] exp_a;
      logic [NRO-1:0] exp_ack;
      if (rst) begin
         for (int i = 0; i < NRO; i++) begin
            m_age[i] = 0; m_wait[i] = 0; m_waiting[i] = 0; m_armed[i] = 1;
            m_hold[i] = '0; m_rdval[i] = '0;
         end
         m_rr = 0;
         m_cpu_do = '0;
         chk("rst_ram_en", 64'(ram_en), 64'd0);
         chk("rst_stall", 64'(cpu_stall), 64'd0);
         chk("rst_ack", 64'(ro_ack), 64'd0);
         chk("rst_ro_data", 64'(ro_data), 64'd0);
         chk("rst_cpu_do", 64'(cpu_do), 64'd0);
      end else begin
         for (int i = 0; i < NRO; i++)
            elig[i] = (m_age[i] == 0) && ro_req[i] && (m_waiting[i] || m_armed[i]);
         g = -1;
         cpu_g = 0;
         for (int k = 0; k < NRO; k++) begin
            idx = (m_rr + k) % NRO;
            if (g < 0 && elig[idx] && m_wait[idx] >= LIM) g = idx;
         end
         exp_stall = (g >= 0) && cpu_en;
         if (g < 0 && cpu_en) cpu_g = 1;
         else if (g < 0)
            for (int k = 0; k < NRO; k++) begin
               idx = (m_rr + k) % NRO;
               if (g < 0 && elig[idx]) g = idx;
            end

         chk("ram_en", 64'(ram_en), 64'(cpu_g || g >= 0));
         if (cpu_g) begin
            chk("ram_a_cpu", 64'(ram_a), 64'(cpu_a));
            chk("ram_we_cpu", 64'(ram_we), 64'(cpu_we));
            chk("ram_di_cpu", 64'(ram_di), 64'(cpu_di));
         end else if (g >= 0) begin
            exp_a = ro_addr[g*AW +: AW];
            chk("ram_a_ro", 64'(ram_a), 64'(exp_a));
            chk("ram_we_ro", 64'(ram_we), 64'd0);
            chk("ram_di_ro", 64'(ram_di), 64'd0);
         end
         chk("cpu_stall", 64'(cpu_stall), 64'(exp_stall));
         for (int i = 0; i < NRO; i++) exp_ack[i] = (m_age[i] == 2);
         chk("ro_ack", 64'(ro_ack), 64'(exp_ack));
         for (int i = 0; i < NRO; i++)
            chk("ro_data", 64'(ro_data[i*DW +: DW]), 64'(m_hold[i]));
         chk("cpu_do", 64'(cpu_do), 64'(m_cpu_do));

         // Advance to the state after the coming clock edge.
         if (cpu_g) begin
            if (cpu_we == '0) m_cpu_do = m_mem[cpu_a];
            else
               for (int b = 0; b < WB; b++)
                  if (cpu_we[b]) m_mem[cpu_a][8*b +: 8] = cpu_di[8*b +: 8];
         end
         for (int i = 0; i < NRO; i++) begin
            if (m_age[i] == 2) m_armed[i] = !ro_req[i];
            else if (m_age[i] == 0 && !ro_req[i]) m_armed[i] = 1;
            if (i == g) begin
               m_rdval[i] = m_mem[ro_addr[i*AW +: AW]];
               m_age[i] = 1; m_wait[i] = 0; m_waiting[i] = 0;
            end else if (m_age[i] == 1) begin
               m_age[i] = 2;
               m_hold[i] = m_rdval[i];
            end else if (m_age[i] == 2) begin
               m_age[i] = 0;
            end else if (elig[i]) begin
               m_waiting[i] = 1;
               m_wait[i] = (m_wait[i] + 1 > LIM) ? LIM : m_wait[i] + 1;
            end else begin
               m_waiting[i] = 0; m_wait[i] = 0;
            end
         end
         if (g >= 0) m_rr = (g + 1) % NRO;
      end
   end

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   int rr_req [14] = '{3, 3, 3, 2, 1, 3, 3, 2, 1, 3, 3, 3, 0, 0};

   initial begin
      rst = 1'b1; cpu_en = 0; cpu_we = '0; cpu_a = '0; cpu_di = '0;
      ro_req = '0; ro_addr = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // CPU write/read with RO idle
      cpu_en = 1; cpu_we = 4'hF; cpu_a = 8'h10; cpu_di = 32'hDEADBEEF;
      mid(); chk("t1_stall_wr", 64'(cpu_stall), 64'd0); adv();
      cpu_we = 4'h0;
      mid(); chk("t1_stall_rd", 64'(cpu_stall), 64'd0); adv();
      cpu_we = 4'hF; cpu_a = 8'h20; cpu_di = 32'h12345678;
      mid(); chk("t1_cpu_do", 64'(cpu_do), 64'hDEADBEEF); adv();
      cpu_we = 4'h1; cpu_a = 8'h10; cpu_di = 32'h000000AA; adv();
      cpu_we = 4'h0; adv();
      cpu_en = 0;
      mid(); chk("t1_cpu_do_part", 64'(cpu_do), 64'hDEADBEAA); adv();

      // RO read in an idle slot
      ro_addr = {8'h20, 8'h10}; ro_req = 2'b01;
      mid(); chk("t2_ram_en", 64'(ram_en), 64'd1); chk("t2_ram_a", 64'(ram_a), 64'h10); adv();
      adv();
      mid(); chk("t2_ack", 64'(ro_ack), 64'b01);
      chk("t2_data", 64'(ro_data[DW-1:0]), 64'hDEADBEAA); adv();
      mid(); chk("t2_no_reack", 64'(ro_ack), 64'd0); chk("t2_no_ram", 64'(ram_en), 64'd0); adv();
      ro_req = 2'b00; adv();

      // Starvation override under continuous CPU traffic
      ro_addr = {8'h10, 8'h10}; cpu_en = 1; cpu_we = 4'h0; cpu_a = 8'h33; ro_req = 2'b10;
      for (int c = 0; c < 8; c++) begin
         mid();
         chk("t3_stall", 64'(cpu_stall), 64'(c == 4));
         chk("t3_ram_a", 64'(ram_a), (c == 4) ? 64'h10 : 64'h33);
         if (c == 6) begin
            chk("t3_ack", 64'(ro_ack), 64'b10);
            chk("t3_data", 64'(ro_data[DW +: DW]), 64'hDEADBEAA);
         end
         adv();
      end
      ro_req = 2'b00; cpu_en = 0; adv();

      // Round-robin between two channels
      ro_addr = {8'h20, 8'h10};
      for (int c = 0; c < 14; c++) begin
         ro_req = NRO'(rr_req[c]);
         mid();
         if (c == 0 || c == 4) chk("t4_ram_a_ch0", 64'(ram_a), 64'h10);
         if (c == 1 || c == 5) chk("t4_ram_a_ch1", 64'(ram_a), 64'h20);
         if (c == 2) begin
            chk("t4_idle", 64'(ram_en), 64'd0);
            chk("t4_ack0", 64'(ro_ack), 64'b01);
         end
         if (c == 3) begin
            chk("t4_ack1", 64'(ro_ack), 64'b10);
            chk("t4_data1", 64'(ro_data[DW +: DW]), 64'h12345678);
         end
         adv();
      end

      // Cancel while waiting behind the CPU
      cpu_en = 1; cpu_we = 4'h0; cpu_a = 8'h44;
      for (int c = 0; c < 6; c++) begin
         ro_req = (c < 2) ? 2'b01 : 2'b00;
         mid();
         chk("t5_ram_a", 64'(ram_a), 64'h44);
         chk("t5_no_ack", 64'(ro_ack), 64'd0);
         adv();
      end
      cpu_en = 0; adv();

      // Reset in the middle of a granted read
      ro_req = 2'b01;
      mid(); chk("t6_grant", 64'(ram_en), 64'd1); adv();
      rst = 1'b1; ro_req = 2'b00;
      mid(); chk("t6_rst_en", 64'(ram_en), 64'd0); chk("t6_rst_ack", 64'(ro_ack), 64'd0);
      chk("t6_rst_data", 64'(ro_data[DW-1:0]), 64'd0); adv();
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         mid(); chk("t6_no_ack", 64'(ro_ack), 64'd0);
         chk("t6_data0", 64'(ro_data[DW-1:0]), 64'd0); adv();
      end
      repeat (2) adv();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/mgmt_sram_arbiter.md
Name: mgmt_sram_arbiter

Overview:
- Parametrised successor to the single-owner DFFRAM hookup inside the management core wrapper.
- Arbitrates one single-port synchronous SRAM (DFFRAM-style: EN, byte WE, A, Di, Do) between the CPU port and NRO read-only client channels (housekeeping, debug).
- The CPU has priority. Read-only channels take idle slots, use round-robin among themselves, and a starvation limit forces a slot by stalling the CPU.
- Sits between mgmt_core and the DFFRAM instance. Any clock-domain crossing of the RO channels is done upstream; everything here is on core_clk.

Parameters:
- AW, 8, SRAM word-address width.
- DW, 32, data width; must be a multiple of 8.
- NRO, 2, number of read-only channels, 1..8.
- STARVE_LIM, 4, cycles an RO request may wait before a slot is forced; must be ≥1.

Ports:
- core_clk  in  1  clock
- core_rst  in  1  asynchronous active-high reset
- cpu_en  in  1  CPU access request, held while cpu_stall
- cpu_we  in  DW/8  byte write enables; 0 = read
- cpu_a  in  AW  CPU address
- cpu_di  in  DW  CPU write data
- cpu_do  out  DW  CPU read data
- cpu_stall  out  1  CPU access not taken this cycle
- ro_req  in  NRO  per-channel read request (level)
- ro_addr  in  NRO*AW  per-channel address, channel i at [i*AW +: AW]
- ro_ack  out  NRO  one-cycle read-complete pulse
- ro_data  out  NRO*DW  per-channel held read data
- ram_en  out  1  SRAM enable
- ram_we  out  DW/8  SRAM byte write enables
- ram_a  out  AW  SRAM address
- ram_di  out  DW  SRAM write data
- ram_do  in  DW  SRAM read data, valid the cycle after an enabled read

Behaviour:
- Reset (async, while core_rst high):
  - All channel states go to IDLE; wait counters, RR pointer, holding registers and cpu_do go to 0.
  - ram_en=0, ram_we=0, cpu_stall=0, ro_ack=0.
- Per-channel FSM: IDLE / WAIT / RD1 / RD2.
  - IDLE: the channel is pending in the same cycle ro_req[i] is high.
  - Pending and not granted → WAIT. A grant from IDLE or WAIT → RD1.
  - RD1 → RD2 unconditionally.
  - RD2: ro_ack[i]=1 for this cycle; then → IDLE.
  - After an ack, a new request needs ro_req[i] low for at least one cycle. Req still high after the ack does not retrigger.
- Wait counter:
  - Counts pending-but-ungranted cycles and saturates at STARVE_LIM.
  - Cleared on grant and on leaving WAIT.
  - A channel is starved when its counter equals STARVE_LIM.
- Cancel: ro_req[i] low while in WAIT → IDLE; no ack, no SRAM access. After a grant the read completes and acks regardless of ro_req.
- Slot decision, combinational each cycle:
  - If any channel is starved: grant the first starved channel at or after the RR pointer. If cpu_en=1, cpu_stall=1.
  - Else if cpu_en=1: grant the CPU; cpu_stall=0.
  - Else if any channel is pending: grant the first pending channel at or after the RR pointer.
  - Else: ram_en=0.
  - After any RO grant, RR pointer ← granted index + 1, wrapping mod NRO.
- SRAM drive:
  - CPU grant: ram_en=1, ram_we=cpu_we, ram_a=cpu_a, ram_di=cpu_di.
  - RO grant: ram_en=1, ram_we=0, ram_a=the channel's address, ram_di=0.
- Latency:
  - CPU read granted in cycle T: cpu_do=ram_do in T+1; cpu_do holds that value until the next CPU read returns.
  - CPU write granted in T: complete in T; cpu_do unchanged.
  - RO read granted in T: ram_do captured at the end of T+1 into the channel holding register. ro_data[i] shows the new value and ro_ack[i]=1 in T+2. ro_data[i] holds until the next ack on that channel.
- Only one SRAM access per cycle, so at most one grant per cycle. Reads to the same address as an in-flight CPU write see the written data, because the SRAM write completes before the next access.
- Reset mid-operation: in-flight reads are discarded, no ack is issued, and holding data returns to 0.

Test Plan:
- RO idle: ro_req=0, NRO=2, STARVE_LIM=4.
  - CPU write 0xDEADBEEF to 0x10 (cpu_we=4'hF) in T, then read 0x10 in T+1 → cpu_do=0xDEADBEEF in T+2, cpu_stall=0 throughout.
  - Partial write cpu_we=4'h1 of 0x000000AA to 0x10, then read → cpu_do=0xDEADBEAA.
- RO read in an idle slot: cpu_en=0, ro_req[0]=1 with addr 0x10 at cycle 0 → ram_en=1 and ram_a=0x10 in cycle 0; ro_ack[0]=1 and ro_data[0]=0xDEADBEAA in cycle 2; no ack in cycle 3 while ro_req is still high.
- Starvation: cpu_en=1 every cycle, ro_req[1]=1 from cycle 0 → cpu_stall=1 only in cycle 4, ram_a=ro_addr[1] in cycle 4, ro_ack[1] in cycle 6, CPU granted in all other cycles.
- Round-robin: cpu_en=0, ro_req=2'b11 held, each channel dropping req for one cycle after its ack → grants alternate ch0, ch1, ch0, ...; acks at cycles 2 (ch0) and 3 (ch1).
- Cancel and reset:
  - ro_req[0] high in cycles 0–1 under continuous CPU traffic, then low → no ram access for ch0 and no ack.
  - Separately, core_rst pulses in cycle 1 after an RO grant in cycle 0 → no ro_ack, ro_data[0]=0, ram_en=0 during reset.
